// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TXD/RXD/CON registers, TX sequencing FSM, RX holding register, level irq.
// Define UART_TX_FIFO_EN to replace the single TX holding register with a TX_FIFO_DEPTH-entry FIFO.
module uart_mmio_ctrl #(
    parameter logic [31:0] BASE_ADDR     = 32'h40000018,
    parameter int unsigned TX_FIFO_DEPTH = 4
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        memwrite,
    input  logic        memread,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        irq
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} tx_state_t;

    tx_state_t  state_reg, state_next;
    logic [7:0] tx_data_reg, tx_last_reg, rx_hold_reg;
    logic       tx_irq_en_reg, rx_irq_en_reg, tx_done_reg, rx_ready_reg;
    logic       rx_overrun_reg, tx_drop_reg, irq_reg;
    logic       sel_txd, sel_rxd, sel_con, con_read, rxd_read, txd_write;
    logic       push, drop, pop, q_empty, tx_full, tx_done_set;
    logic [7:0] q_head;
    logic       unused_ok;

    assign sel_txd   = (addr == BASE_ADDR);
    assign sel_rxd   = (addr == BASE_ADDR + 32'd4);
    assign sel_con   = (addr == BASE_ADDR + 32'd8);
    assign con_read  = memread && sel_con;
    assign rxd_read  = memread && sel_rxd;
    assign txd_write = memwrite && sel_txd;
    assign push      = txd_write && !tx_full;
    assign drop      = txd_write && tx_full;

`ifdef UART_TX_FIFO_EN
    localparam int AW = (TX_FIFO_DEPTH > 1) ? $clog2(TX_FIFO_DEPTH) : 1;
    logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;

    always_ff @(posedge sysclk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= wdata[7:0];
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (pop && !push) count_reg <= count_reg - 1'b1;
        end
    end

    assign q_head    = fifo_mem[rd_ptr_reg];
    assign q_empty   = (count_reg == '0);
    assign tx_full   = (count_reg == (AW+1)'(TX_FIFO_DEPTH));
    assign unused_ok = ^wdata[31:8];
`else
    logic [7:0] hold_reg;
    logic       hold_valid_reg;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            hold_reg       <= 8'd0;
            hold_valid_reg <= 1'b0;
        end else if (push) begin
            hold_reg       <= wdata[7:0];
            hold_valid_reg <= 1'b1;
        end else if (pop) begin
            hold_valid_reg <= 1'b0;
        end
    end

    assign q_head    = hold_reg;
    assign q_empty   = !hold_valid_reg;
    assign tx_full   = hold_valid_reg;
    assign unused_ok = ^{wdata[31:8], TX_FIFO_DEPTH[0]};
`endif

    // IDLE also waits for tx_busy low so a frame left running across reset is never overlapped.
    always_comb begin
        state_next  = state_reg;
        pop         = 1'b0;
        tx_done_set = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!q_empty && !tx_busy) begin
                    pop        = 1'b1;
                    state_next = S_START;
                end
            end
            S_START:     state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: if (tx_busy) state_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    tx_done_set = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            tx_data_reg    <= 8'd0;
            tx_last_reg    <= 8'd0;
            rx_hold_reg    <= 8'd0;
            tx_irq_en_reg  <= 1'b0;
            rx_irq_en_reg  <= 1'b0;
            tx_done_reg    <= 1'b0;
            rx_ready_reg   <= 1'b0;
            rx_overrun_reg <= 1'b0;
            tx_drop_reg    <= 1'b0;
            irq_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (pop)  tx_data_reg <= q_head;
            if (push) tx_last_reg <= wdata[7:0];
            if (memwrite && sel_con) begin
                tx_irq_en_reg <= wdata[0];
                rx_irq_en_reg <= wdata[1];
            end
            // Sticky bits: a set in the same cycle as a CON read wins.
            tx_done_reg <= tx_done_set || (tx_done_reg && !con_read);
            tx_drop_reg <= drop || (tx_drop_reg && !con_read);
            if (rx_valid) begin
                rx_hold_reg  <= rx_data;
                rx_ready_reg <= 1'b1;
            end else if (rxd_read) begin
                rx_ready_reg <= 1'b0;
            end
            rx_overrun_reg <= (rx_valid && rx_ready_reg && !rxd_read) ||
                              (rx_overrun_reg && !con_read);
            irq_reg <= (tx_irq_en_reg && tx_done_reg) || (rx_irq_en_reg && rx_ready_reg);
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (sel_txd)
            rdata = {24'd0, tx_last_reg};
        else if (sel_rxd)
            rdata = {24'd0, rx_hold_reg};
        else if (sel_con)
            rdata = {25'd0, tx_drop_reg, rx_overrun_reg, tx_full, rx_ready_reg,
                     tx_done_reg, rx_irq_en_reg, tx_irq_en_reg};
    end

    assign tx_data  = tx_data_reg;
    assign tx_start = (state_reg == S_START);
    assign irq      = irq_reg;
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: sent bytes are scoreboarded against tx_start pulses,
// register reads and irq are compared against constants derived from the register map.
module tb_uart_mmio_ctrl;
    localparam logic [31:0] TXD = 32'h40000018;
    localparam logic [31:0] RXD = 32'h4000001C;
    localparam logic [31:0] CON = 32'h40000020;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'd0, wdata = 32'd0, rdata;
    logic        memwrite = 1'b0, memread = 1'b0;
    logic [7:0]  tx_data, rx_data = 8'd0;
    logic        tx_start, tx_busy, rx_valid = 1'b0, irq;
    logic        busy_force = 1'b0;
    int          busy_cnt = 0;
    int          errors = 0, checks = 0, start_count = 0;
    logic [7:0]  sb [$];

    uart_mmio_ctrl dut (
        .sysclk(sysclk), .reset(reset), .addr(addr), .wdata(wdata),
        .memwrite(memwrite), .memread(memread), .rdata(rdata),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
    );

    always #5 sysclk = ~sysclk;

    // Sender model: busy for 10 cycles after each start; not reset with the controller.
    always @(posedge sysclk) begin
        if (tx_start && busy_cnt == 0) busy_cnt <= 10;
        else if (busy_cnt != 0)        busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) || busy_force;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    always @(negedge sysclk) begin
        if (tx_start) begin
            start_count++;
            if (sb.size() == 0) check_eq("start_unexpected", 32'd1, 32'd0);
            else                check_eq("tx_byte", {24'd0, tx_data}, {24'd0, sb.pop_front()});
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge sysclk);
        addr = a; wdata = d; memwrite = 1'b1;
        @(posedge sysclk); #1;
        memwrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge sysclk);
        addr = a; memread = 1'b1;
        #1 d = rdata;
        @(posedge sysclk); #1;
        memread = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        @(negedge sysclk);
        rx_valid = 1'b1; rx_data = d;
        @(posedge sysclk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        reset = 1'b1;
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 600) begin @(posedge sysclk); n++; end
        repeat (3) @(posedge sysclk);
        while (tx_busy && n < 600) begin @(posedge sysclk); n++; end
        repeat (3) @(posedge sysclk);
        if (n >= 600) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    logic [31:0] rd;
    int          starts_before, n;

    initial begin
        // Reset state
        do_reset();
        bus_read(CON, rd); check_eq("reset_con", rd, 32'h0);
        bus_read(TXD, rd); check_eq("reset_txd", rd, 32'h0);
        bus_read(RXD, rd); check_eq("reset_rxd", rd, 32'h0);
        check_eq("reset_irq", {31'd0, irq}, 32'd0);
        repeat (20) @(posedge sysclk);
        check_eq("reset_no_start", start_count, 0);

        // Single byte with start latency
        sb.push_back(8'h55);
        bus_write(TXD, 32'h55);
        check_eq("lat_edge_n", {31'd0, tx_start}, 32'd0);
        @(posedge sysclk); #1;
        check_eq("lat_edge_n1", {31'd0, tx_start}, 32'd1);
        wait_idle("single");
        bus_read(CON, rd); check_eq("single_done", rd, 32'h4);
        bus_read(CON, rd); check_eq("single_done_clr", rd, 32'h0);
        check_eq("single_starts", start_count, 1);

        // Back-to-back writes while the sender is busy: overflow drops
        busy_force = 1'b1;
`ifdef UART_TX_FIFO_EN
        for (int i = 1; i <= 4; i++) sb.push_back(8'(i));
`else
        sb.push_back(8'h01);
`endif
        for (int i = 1; i <= 5; i++) bus_write(TXD, 32'(i));
        bus_read(CON, rd); check_eq("burst_full_drop", rd, 32'h50);
        bus_read(TXD, rd);
`ifdef UART_TX_FIFO_EN
        check_eq("burst_last", rd, 32'h04);
`else
        check_eq("burst_last", rd, 32'h01);
`endif
        starts_before = start_count;
        busy_force = 1'b0;
        wait_idle("burst");
        check_eq("burst_sb_empty", sb.size(), 0);
        bus_read(CON, rd); check_eq("burst_done", rd, 32'h4);

        // RX interrupt
        bus_write(CON, 32'h2);
        rx_pulse(8'hA3);
        check_eq("rx_irq_lag", {31'd0, irq}, 32'd0);
        @(posedge sysclk); #1;
        check_eq("rx_irq_rise", {31'd0, irq}, 32'd1);
        bus_read(RXD, rd); check_eq("rx_byte", rd, 32'hA3);
        @(posedge sysclk); #1;
        check_eq("rx_irq_fall", {31'd0, irq}, 32'd0);
        bus_read(CON, rd); check_eq("rx_con_after", rd, 32'h2);
        bus_write(CON, 32'h0);

        // Overrun
        rx_pulse(8'h10);
        rx_pulse(8'h20);
        bus_read(RXD, rd); check_eq("ovr_byte", rd, 32'h20);
        bus_read(CON, rd); check_eq("ovr_con", rd, 32'h20);
        bus_read(CON, rd); check_eq("ovr_clr", rd, 32'h0);

        // RX pulse coinciding with an RXD read
        rx_pulse(8'h10);
        @(negedge sysclk);
        rx_valid = 1'b1; rx_data = 8'h20; addr = RXD; memread = 1'b1;
        #1 rd = rdata;
        @(posedge sysclk); #1;
        rx_valid = 1'b0; memread = 1'b0;
        check_eq("sim_read_old", rd, 32'h10);
        bus_read(CON, rd); check_eq("sim_con", rd, 32'h08);
        bus_read(RXD, rd); check_eq("sim_new", rd, 32'h20);

        // Reset during WAIT_DONE with bytes queued
        sb.push_back(8'hA1);
        bus_write(TXD, 32'hA1);
        n = 0;
        while (!tx_busy && n < 50) begin @(posedge sysclk); n++; end
        if (n >= 50) check_eq("midreset_busy_timeout", 32'd1, 32'd0);
        bus_write(TXD, 32'hA2);
        bus_write(TXD, 32'hA3);
        do_reset();
        starts_before = start_count;
        repeat (40) @(posedge sysclk);
        check_eq("midreset_no_start", start_count - starts_before, 0);
        bus_read(CON, rd); check_eq("midreset_con", rd, 32'h0);
        bus_read(TXD, rd); check_eq("midreset_txd", rd, 32'h0);
        check_eq("midreset_tx_data", {24'd0, tx_data}, 32'h0);
        check_eq("end_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_mmio_ctrl.md
# uart_mmio_ctrl

Memory-mapped controller that sits between the single-cycle CPU data bus and the UART sender/receiver pair. It decodes three peripheral addresses and sequences the sender through a start/busy/done handshake. It buffers received bytes and outgoing bytes, and raises a level interrupt to the CPU. The controller owns all UART status; the CPU never drives the sender directly.

## Interface
Parameters:
- `BASE_ADDR`, 32'h40000018: address of TXD; RXD is BASE+4, CON is BASE+8.
- `TX_FIFO_DEPTH`, 4: TX FIFO entries, a power of two, used only when the FIFO is compiled in.

Ports:
- `sysclk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  32  CPU byte address.
- `wdata`  in  32  CPU write data; only bits [7:0] are used for TXD; CON uses [1:0].
- `memwrite`  in  1  write strobe, one cycle per store.
- `memread`  in  1  read strobe; read side-effects apply at the edge ending the cycle.
- `rdata`  out  32  combinational read data; zero when no address matches.
- `tx_data`  out  8  byte presented to the sender; held stable from `tx_start` until done.
- `tx_start`  out  1  one-cycle start pulse to the sender.
- `tx_busy`  in  1  sender busy, high while the frame shifts out.
- `rx_data`  in  8  receiver byte; valid when `rx_valid` is high.
- `rx_valid`  in  1  one-cycle pulse per received byte.
- `irq`  out  1  level interrupt.

## Operation
CON layout (read):
- [0] tx_irq_en (R/W)
- [1] rx_irq_en (R/W)
- [2] tx_done: sticky; cleared by a CON read
- [3] rx_ready
- [4] tx_full
- [5] rx_overrun: sticky; cleared by a CON read
- [6] tx_drop: sticky; cleared by a CON read
- [31:7] zero

Register access:
- A CON write updates only bits [1:0].
- TXD write with tx_full=0: enqueue `wdata[7:0]`.
- TXD write with tx_full=1: byte discarded and tx_drop set.
- TXD read returns the last enqueued byte in [7:0].
- RXD read returns the RX holding byte in [7:0] and clears rx_ready.

TX FSM:
- IDLE: if the queue is non-empty, pop into `tx_data` and go to START.
- START: `tx_start`=1 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: stay until `tx_busy`=1, then go to WAIT_DONE.
- WAIT_DONE: stay until `tx_busy`=0, then set tx_done and go to IDLE.

RX path:
- `rx_valid` latches `rx_data` into the holding register and sets rx_ready.
- If rx_ready is already 1 and no RXD read occurs that cycle, the new byte overwrites the holding register and rx_overrun is set.

Interrupt:
- `irq` = (tx_irq_en & tx_done) | (rx_irq_en & rx_ready), registered.

Simultaneous events:
- `rx_valid` with an RXD read in the same cycle: the new byte is latched, rx_ready stays 1, no overrun.
- tx_done being set with a CON read in the same cycle: set wins, so the bit reads 1 next time.
- TXD write with a pop in the same cycle: both take effect; occupancy is unchanged.

## Timing
- Reset values: `rdata` reflects zeroed registers; `tx_data`=0, `tx_start`=0, `irq`=0; FSM in IDLE; queue empty; all CON bits 0.
- `reset` asserted mid-frame: FSM returns to IDLE and the queue is flushed. The sender is not aborted; the next start waits until `tx_busy`=0 in IDLE.
- Latency from a TXD write (queue empty, IDLE) to `tx_start`: 2 cycles. The write lands at edge N, the pop at edge N+1, and `tx_start` is high during cycle N+2.
- `irq` rises one cycle after the causing status bit sets.
- `rdata` is combinational from `addr` and the current register state, with zero wait states.

## Configuration
- `UART_TX_FIFO_EN` defined: TXD feeds a `TX_FIFO_DEPTH`-entry circular FIFO with wrapping read/write pointers and a count of width log2(depth)+1. tx_full = (count == depth).
- `UART_TX_FIFO_EN` undefined: a single holding register. tx_full = 1 from the TXD write until the pop in IDLE, so a second write in that window is dropped.

## Test plan
- Reset, then read CON → 32'h0, `irq`=0, `tx_start` stays 0 for 20 cycles.
- Write 0x55 to TXD; model sender busy 10 cycles after start → exactly one `tx_start` pulse with `tx_data`=0x55; CON[2]=1 after busy falls; a second CON read returns [2]=0.
- FIFO build: write 0x01..0x05 back-to-back while the sender is busy → bytes 0x01..0x04 sent in order, CON[6]=1. Non-FIFO build: only 0x01 sent, CON[6]=1.
- Pulse `rx_valid` with 0xA3, CON=0x2 → `irq`=1 next cycle; RXD read returns 0xA3 and `irq` falls.
- Two `rx_valid` pulses (0x10, 0x20) with no read → RXD=0x20, CON[5]=1. Repeat with an RXD read in the same cycle as the second pulse → CON[5]=0, CON[3]=1.
- Assert `reset` during WAIT_DONE with 2 bytes queued → queue empty, FSM IDLE, no `tx_start` after reset.
